// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: credit-based instruction prefetcher feeding the IF/ID register from an in-order imem.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect queues a fault marker and halts fetch.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        out_fault
`endif
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  // Handshakes: a transfer happens in any cycle where valid && ready are both high;
  // valid never depends on ready, and the payload is held while valid waits for ready.

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   instr_d [FIFO_DEPTH];
  logic [31:0]   pc_q [FIFO_DEPTH];
  logic [31:0]   pc_d [FIFO_DEPTH];
  logic          req_fire, pop, keep_rsp, run;
  logic [31:0]   redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN, FAULT} state_e;
  state_e state_q, state_d;
  logic   fault_q [FIFO_DEPTH];
  logic   fault_d [FIFO_DEPTH];
  logic   misalign;
  assign run       = (state_q == RUN);
  assign misalign  = (redirect_pc[1:0] != 2'b00);
  assign redir_pc  = redirect_pc;
  assign out_fault = out_valid && fault_q[rd_ptr_q];
`else
  assign run      = 1'b1;
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Credit rule: queued plus in-flight never exceeds the FIFO, so a response always has a slot.
  assign imem_req_valid = rst_n && run && !redirect_valid &&
                          (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_valid      = (count_q != '0);
  assign out_instr      = instr_q[rd_ptr_q];
  assign out_pc         = pc_q[rd_ptr_q];
  assign pop            = out_valid && out_ready;
  assign keep_rsp       = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    state_d       = state_q;
    fault_d       = fault_q;
`endif
    if (redirect_valid) begin
      // Everything still in flight belongs to the abandoned path, except a response landing now.
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_d = RUN;
      if (misalign) begin
        instr_d[0] = NOP;
        pc_d[0]    = redirect_pc;
        fault_d[0] = 1'b1;
        wr_ptr_d   = AW'(1);
        count_d    = CW'(1);
        state_d    = FAULT;
      end
`endif
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (keep_rsp) begin
        instr_d[wr_ptr_q] = imem_rsp_data;
        pc_d[wr_ptr_q]    = rsp_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d[wr_ptr_q] = 1'b0;
`endif
        wr_ptr_d = wr_ptr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(keep_rsp) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= NOP;
        pc_q[i]    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_q[i] <= 1'b0;
`endif
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q <= RUN;
`endif
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q       <= fault_d;
      state_q       <= state_d;
`endif
    end
  end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: random and directed stimulus against an in-order imem model, with a
// request-level reference model feeding an expected queue that a monitor drains.
module tb_riscv_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        out_fault;
`endif

  riscv_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .out_fault(out_fault)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  logic rdy_rand = 1'b0, rdy_val = 1'b1, ordy_rand = 1'b0, ordy_val = 1'b1;

  // Reference model state: FIFO image {fault, pc, instr}, in-flight requests {stale, pc}, imem queue {due, addr}.
  logic [64:0] exp_q[$];
  logic [32:0] infl_q[$];
  logic [63:0] pend_q[$];
  logic [31:0] exp_pc = RESET_PC;
  logic        m_fault = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [31:0] pc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
    chk({name, "_valid"}, out_valid, 1);
    chk(name, out_pc, pc);
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFF0;
      1:       return r & 32'h0000_FFFC;
      2:       return r & 32'hFFFF_FFFC;
      default: return r;
    endcase
  endfunction

  // imem: accepts per rdy settings, answers in order after lat_min..lat_max cycles.
  always @(posedge clk) begin
    #2;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    out_ready      = ordy_rand ? ($urandom_range(0, 2) != 0) : ordy_val;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (rst_n && pend_q.size() != 0 && pend_q[0][63:32] <= 32'(cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0][31:0]);
      void'(pend_q.pop_front());
    end
  end

  // ---------------- scoreboard: monitor first, then model update ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      exp_q.delete();
      infl_q.delete();
      pend_q.delete();
      exp_pc  = RESET_PC;
      m_fault = 1'b0;
    end else begin
      chk("req_valid", imem_req_valid,
          32'(!m_fault && !redirect_valid && (exp_q.size() + infl_q.size() < DEPTH)));
      chk("out_valid", out_valid, 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0][63:32]);
        chk("out_instr", out_instr, exp_q[0][31:0]);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("out_fault", out_fault, 32'(exp_q[0][64]));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
      if (imem_rsp_valid && infl_q.size() != 0) begin
        e = infl_q.pop_front();
        if (!e[32] && !redirect_valid) exp_q.push_back({1'b0, e[31:0], mem_word(e[31:0])});
      end
      if (redirect_valid) begin
        exp_q.delete();
        foreach (infl_q[i]) infl_q[i][32] = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          exp_q.push_back({1'b1, redirect_pc, NOP});
          m_fault = 1'b1;
        end else begin
          m_fault = 1'b0;
          exp_pc  = redirect_pc;
        end
`else
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_pc);
        infl_q.push_back({1'b0, exp_pc});
        pend_q.push_back({32'(cyc + $urandom_range(lat_min, lat_max)), imem_req_addr});
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_pc", out_pc, RESET_PC);
    step();
    rst_n = 1'b1;

    // Streaming after reset: request in the release cycle, first instruction two cycles later.
    @(negedge clk);
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    chk("first_out_early", out_valid, 0);
    @(negedge clk);
    chk("first_out_valid", out_valid, 1);
    chk("first_out_pc", out_pc, RESET_PC);
    @(negedge clk);
    chk("second_out_pc", out_pc, RESET_PC + 32'd4);
    repeat (15) step();

    // Consumer stall: FIFO fills, fetch stops on credits, then resumes.
    ordy_val = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    step();
    ordy_val = 1'b1;
    repeat (12) step();

    // imem back-pressure: address must hold.
    rdy_val = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_addr", imem_req_addr, exp_pc);
      chk("hold_valid", imem_req_valid, 1);
    end
    step();
    rdy_val = 1'b1;

    // Redirect with responses in flight.
    lat_min = 3;
    lat_max = 3;
    repeat (12) step();
    redirect(32'h0000_0200);
    wait_out("redir_pc", 32'h0000_0200);
    repeat (8) step();

    // Address wrap.
    lat_min = 1;
    lat_max = 1;
    redirect(32'hFFFF_FFF8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == 32'h0) found = 1'b1;
    end
    chk("wrap_pc_zero", 32'(found), 1);
    step();

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1000;
    step();
    redirect_pc    = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    wait_out("b2b_pc", 32'h0000_2000);
    step();

`ifdef FETCH_MISALIGN_TRAP_EN
    ordy_val = 1'b0;
    redirect(32'h0000_0102);
    @(negedge clk);
    chk("fault_valid", out_valid, 1);
    chk("fault_flag", 32'(out_fault), 1);
    chk("fault_pc", out_pc, 32'h0000_0102);
    repeat (5) begin
      @(negedge clk);
      chk("fault_halt", imem_req_valid, 0);
    end
    step();
    ordy_val = 1'b1;
    redirect(32'h0000_0100);
    wait_out("fault_resume", 32'h0000_0100);
`else
    redirect(32'h0000_0302);
    wait_out("misalign_mask", 32'h0000_0300);
`endif
    step();

    // Reset mid-transaction.
    lat_min = 2;
    lat_max = 3;
    repeat (6) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_req_valid", imem_req_valid, 0);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_pc", out_pc, RESET_PC);
    chk("rst2_out_instr", out_instr, NOP);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_first_req", imem_req_valid, 1);
    chk("rst2_first_addr", imem_req_addr, RESET_PC);
    repeat (10) step();

    // Random traffic.
    rdy_rand  = 1'b1;
    ordy_rand = 1'b1;
    lat_min   = 1;
    lat_max   = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = pick_pc();
        step();
        if ($urandom_range(0, 3) == 0) begin
          redirect_pc = pick_pc();
          step();
        end
        redirect_valid = 1'b0;
      end else begin
        step();
      end
    end

    rdy_rand  = 1'b0;
    ordy_rand = 1'b0;
    rdy_val   = 1'b1;
    ordy_val  = 1'b1;
    redirect(32'h0000_0400);
    wait_out("final_pc", 32'h0000_0400);
    repeat (20) step();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
